trap_sequencer: RTL

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// Trap entry sequencer: saves PSW/PC to the vector block and loads the new context.
// Optional TRAP_PENDING_EN latches irq rising edges instead of using irq levels.
module trap_sequencer #(
    parameter int NUM_SRC = 4,
    parameter int VW      = $clog2(NUM_SRC + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               fault,
    input  logic               privileged,
    input  logic               take,
    output logic               trap_req,
    output logic               busy,
    output logic               done,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic               fault_ack,
    output logic [VW-1:0]      vec_idx,
    output logic               con_ROM_out,
    output logic               GPR_in,
    output logic               GPR_out,
    output logic               MAR_in,
    output logic               MDR_in,
    output logic               MDR_out,
    output logic               PSW_in,
    output logic               PSW_out,
    output logic               RAM_enable_read,
    output logic               RAM_enable_write,
    output logic               Y_in,
    output logic               Z_in,
    output logic               Z_out,
    output logic [2:0]         GPR_select,
    output logic [2:0]         ALU_control
);

    typedef enum logic [3:0] {
        IDLE, VEC, SPSW, A1, SPC, A2, LPSW, A3, LPC
    } state_t;

    state_t             state, state_nxt;
    logic [VW-1:0]      vec_nxt;
    logic [VW-1:0]      winner;
    logic [NUM_SRC-1:0] pending;

`ifdef TRAP_PENDING_EN
    logic [NUM_SRC-1:0] irq_q;

    // A new edge wins over the ack that clears the same source.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~irq_ack) | (irq & ~irq_q);
        end
    end
`else
    assign pending = irq;
`endif

    assign trap_req = fault | (|pending & ~privileged);

    always_comb begin
        winner = '0;
        if (!fault) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (pending[i]) winner = VW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            vec_idx <= '0;
        end else begin
            state   <= state_nxt;
            vec_idx <= vec_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec_idx;
        case (state)
            IDLE: begin
                if (take && trap_req) begin
                    state_nxt = VEC;
                    vec_nxt   = winner;
                end
            end
            VEC:  state_nxt = SPSW;
            SPSW: state_nxt = A1;
            A1:   state_nxt = SPC;
            SPC:  state_nxt = A2;
            A2:   state_nxt = LPSW;
            LPSW: state_nxt = A3;
            A3:   state_nxt = LPC;
            LPC: begin
                state_nxt = IDLE;
                vec_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                vec_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy             = (state != IDLE);
        done             = 1'b0;
        irq_ack          = '0;
        fault_ack        = 1'b0;
        con_ROM_out      = 1'b0;
        GPR_in           = 1'b0;
        GPR_out          = 1'b0;
        MAR_in           = 1'b0;
        MDR_in           = 1'b0;
        MDR_out          = 1'b0;
        PSW_in           = 1'b0;
        PSW_out          = 1'b0;
        RAM_enable_read  = 1'b0;
        RAM_enable_write = 1'b0;
        Y_in             = 1'b0;
        Z_in             = 1'b0;
        Z_out            = 1'b0;
        GPR_select       = 3'b000;
        ALU_control      = 3'b000;
        case (state)
            VEC: begin
                con_ROM_out = 1'b1;
                MAR_in      = 1'b1;
                Y_in        = 1'b1;
            end
            SPSW: begin
                PSW_out          = 1'b1;
                MDR_in           = 1'b1;
                RAM_enable_write = 1'b1;
                ALU_control      = 3'b010;
                Z_in             = 1'b1;
            end
            A1: begin
                Z_out  = 1'b1;
                MAR_in = 1'b1;
                Y_in   = 1'b1;
            end
            SPC: begin
                GPR_out          = 1'b1;
                GPR_select       = 3'b001;
                MDR_in           = 1'b1;
                RAM_enable_write = 1'b1;
                ALU_control      = 3'b010;
                Z_in             = 1'b1;
            end
            A2: begin
                Z_out           = 1'b1;
                MAR_in          = 1'b1;
                Y_in            = 1'b1;
                RAM_enable_read = 1'b1;
            end
            LPSW: begin
                MDR_out     = 1'b1;
                PSW_in      = 1'b1;
                ALU_control = 3'b010;
                Z_in        = 1'b1;
            end
            A3: begin
                Z_out           = 1'b1;
                MAR_in          = 1'b1;
                RAM_enable_read = 1'b1;
            end
            LPC: begin
                MDR_out    = 1'b1;
                GPR_in     = 1'b1;
                GPR_select = 3'b001;
                done       = 1'b1;
                fault_ack  = (vec_idx == '0);
                for (int i = 0; i < NUM_SRC; i++) begin
                    irq_ack[i] = (vec_idx == VW'(i + 1));
                end
            end
            default: ;
        endcase
    end

endmodule
